// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues in-order imem word fetches and hands PC/instruction pairs to the F/D register
// Ports:
//    clk_i, reset_ni                  clock, synchronous active-low reset
//    redirect_valid_i, redirect_pc_i  reload the PC and squash everything fetched or still in flight
//    imem_req_valid_o/addr_o/ready_i  word fetch request at the current PC
//    imem_rsp_valid_i/data_i          in-order instruction responses
//    valid_o, instruction_o, PC_o     head of the fetch FIFO, popped when ready_i is high
module fetch_stage #(
   parameter logic [63:0] ResetPC   = 64'h0,
   parameter int unsigned FifoDepth = 2
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        redirect_valid_i,
   input  logic [63:0] redirect_pc_i,
   output logic        imem_req_valid_o,
   output logic [63:0] imem_req_addr_o,
   input  logic        imem_req_ready_i,
   input  logic        imem_rsp_valid_i,
   input  logic [31:0] imem_rsp_data_i,
   output logic        valid_o,
   output logic [31:0] instruction_o,
   output logic [63:0] PC_o,
   input  logic        ready_i
);
   localparam int unsigned Aw = $clog2(FifoDepth);
   localparam logic [31:0] Nop = 32'h0000_0013;
   typedef logic [Aw:0] ptr_t;
   typedef logic [Aw+1:0] cnt_t;
   logic [63:0] pc_q, pc_d;
   // head = oldest entry, fill = oldest unfilled entry, tail = next free slot;
   // entries in [head, fill) are filled, so no per-entry flag is stored
   ptr_t head_q, head_d, fill_q, fill_d, tail_q, tail_d, drop_q, drop_d;
   logic run_q, run_d;
   logic [63:0] pc_mem_q [FifoDepth];
   logic [63:0] pc_mem_d [FifoDepth];
   logic [31:0] data_mem_q [FifoDepth];
   logic [31:0] data_mem_d [FifoDepth];
   ptr_t count, unfilled;
   logic empty, accept, pop, rsp_drop, rsp_fill;
   assign count    = tail_q - head_q;
   assign unfilled = tail_q - fill_q;
   assign empty    = count == '0;
   // run_q keeps the request port quiet for the first cycle after reset
   assign imem_req_valid_o = run_q && !redirect_valid_i && (cnt_t'(count) + cnt_t'(drop_q) < cnt_t'(FifoDepth));
   assign imem_req_addr_o  = pc_q;
   assign accept   = imem_req_valid_o && imem_req_ready_i;
   assign rsp_drop = imem_rsp_valid_i && drop_q != '0;
   assign rsp_fill = imem_rsp_valid_i && drop_q == '0 && unfilled != '0;
   assign valid_o       = fill_q != head_q;
   assign pop           = valid_o && ready_i;
   assign instruction_o = valid_o ? data_mem_q[head_q[Aw-1:0]] : Nop;
   assign PC_o          = empty ? 64'h0 : pc_mem_q[head_q[Aw-1:0]];
   always_comb begin
      pc_d       = pc_q;
      head_d     = head_q;
      fill_d     = fill_q;
      tail_d     = tail_q;
      drop_d     = drop_q;
      run_d      = 1'b1;
      pc_mem_d   = pc_mem_q;
      data_mem_d = data_mem_q;
      if (redirect_valid_i) begin
         pc_d   = {redirect_pc_i[63:2], 2'b00};
         head_d = '0;
         fill_d = '0;
         tail_d = '0;
         // every unfilled entry still owes a response; one arriving now is already consumed
         drop_d = drop_q + unfilled - ptr_t'(rsp_drop || rsp_fill);
      end else begin
         if (accept) begin
            pc_mem_d[tail_q[Aw-1:0]] = pc_q;
            tail_d = tail_q + 1'b1;
            pc_d   = pc_q + 64'd4;
         end
         if (rsp_drop) drop_d = drop_q - 1'b1;
         if (rsp_fill) begin
            data_mem_d[fill_q[Aw-1:0]] = imem_rsp_data_i;
            fill_d = fill_q + 1'b1;
         end
         if (pop) head_d = head_q + 1'b1;
      end
   end
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         pc_q   <= ResetPC;
         head_q <= '0;
         fill_q <= '0;
         tail_q <= '0;
         drop_q <= '0;
         run_q  <= 1'b0;
         for (int i = 0; i < FifoDepth; i++) begin
            pc_mem_q[i]   <= '0;
            data_mem_q[i] <= '0;
         end
      end else begin
         pc_q       <= pc_d;
         head_q     <= head_d;
         fill_q     <= fill_d;
         tail_q     <= tail_d;
         drop_q     <= drop_d;
         run_q      <= run_d;
         pc_mem_q   <= pc_mem_d;
         data_mem_q <= data_mem_d;
      end
   end
   // a response must either be owed to a squashed request or fill a live entry
   rsp_legal_a: assert property (@(posedge clk_i) disable iff (!reset_ni)
      imem_rsp_valid_i |-> (drop_q != '0 || unfilled != '0));
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench with a queue-level fetch model, an imem model and program-order checks
module tb_fetch_stage;
   localparam logic [63:0] RstPc = 64'hFFFF_FFFF_FFFF_FFFC;
   localparam int D = 2;
   localparam logic [31:0] Nop = 32'h0000_0013;
   logic        clk_i = 1'b0;
   logic        reset_ni = 1'b0;
   logic        redirect_valid_i = 1'b0;
   logic [63:0] redirect_pc_i = '0;
   logic        imem_req_ready_i = 1'b1;
   logic        imem_rsp_valid_i = 1'b0;
   logic [31:0] imem_rsp_data_i = '0;
   logic        ready_i = 1'b1;
   logic        imem_req_valid_o, valid_o;
   logic [63:0] imem_req_addr_o, PC_o;
   logic [31:0] instruction_o;

   fetch_stage #(.ResetPC(RstPc), .FifoDepth(D)) dut (
      .clk_i(clk_i), .reset_ni(reset_ni),
      .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
      .imem_req_valid_o(imem_req_valid_o), .imem_req_addr_o(imem_req_addr_o), .imem_req_ready_i(imem_req_ready_i),
      .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_data_i(imem_rsp_data_i),
      .valid_o(valid_o), .instruction_o(instruction_o), .PC_o(PC_o), .ready_i(ready_i));

   always #5 clk_i = ~clk_i;

   typedef struct {logic [63:0] pc; logic [31:0] data; bit filled;} ent_t;
   typedef struct {logic [63:0] addr; int due;} req_t;
   ent_t q[$];
   req_t pend[$];
   int drop = 0;
   logic [63:0] mpc = '0;
   logic [63:0] seq_pc = '0;
   bit run = 0;
   bit armed = 0;
   int cyc = 0;
   int lat = 1;
   int n_chk = 0;
   int n_pass = 0;
   int first_valid_cyc = -1;
   int rel_cyc = 0;
   logic [63:0] got_pc[$];
   logic [31:0] got_ins[$];

   function automatic logic [31:0] inst_of(input logic [63:0] a);
      return a[31:0] ^ 32'h1234_5678;
   endfunction

   function automatic bit m_req();
      return run && !redirect_valid_i && (q.size() + drop < D);
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, got, want);
   endtask

   // memory + model advance on each edge, using only bench-driven signals
   always @(posedge clk_i) begin
      bit rv, acc, rsp, popm;
      int uf;
      rv = m_req();
      acc = rv && imem_req_ready_i;
      rsp = imem_rsp_valid_i;
      popm = q.size() > 0 && q[0].filled && ready_i;
      uf = 0;
      foreach (q[i]) if (!q[i].filled) uf++;
      if (!reset_ni) begin
         q.delete();
         pend.delete();
         drop = 0;
         mpc = RstPc;
         seq_pc = RstPc;
         run = 0;
         armed = 1;
      end else begin
         run = 1;
         if (rsp && pend.size() > 0) void'(pend.pop_front());
         if (redirect_valid_i) begin
            drop = drop + uf - ((rsp && (drop > 0 || uf > 0)) ? 1 : 0);
            q.delete();
            mpc = {redirect_pc_i[63:2], 2'b00};
            seq_pc = mpc;
         end else begin
            if (rsp) begin
               if (drop > 0) drop--;
               else begin
                  for (int i = 0; i < q.size(); i++)
                     if (!q[i].filled) begin
                        q[i].data = imem_rsp_data_i;
                        q[i].filled = 1;
                        break;
                     end
               end
            end
            if (popm) void'(q.pop_front());
            if (acc) begin
               q.push_back('{mpc, 32'h0, 1'b0});
               pend.push_back('{mpc, cyc + lat});
               mpc = mpc + 64'd4;
            end
         end
      end
      cyc++;
      #1;
      imem_rsp_valid_i = pend.size() > 0 && pend[0].due <= cyc;
      imem_rsp_data_i = imem_rsp_valid_i ? inst_of(pend[0].addr) : 32'h0;
   end

   // single compare process against the model, plus program-order/pairing checks on transfers
   always @(negedge clk_i) begin
      if (armed) begin
         chk("req_valid", {63'h0, imem_req_valid_o}, {63'h0, m_req()});
         if (m_req()) chk("req_addr", imem_req_addr_o, mpc);
         chk("valid_o", {63'h0, valid_o}, {63'h0, q.size() > 0 && q[0].filled});
         if (q.size() > 0 && q[0].filled) begin
            chk("pc_o", PC_o, q[0].pc);
            chk("instr_o", {32'h0, instruction_o}, {32'h0, q[0].data});
         end else if (q.size() == 0) begin
            chk("pc_o_empty", PC_o, 64'h0);
            chk("instr_o_empty", {32'h0, instruction_o}, {32'h0, Nop});
         end
         if (valid_o && ready_i && reset_ni && !redirect_valid_i) begin
            chk("seq_pc", PC_o, seq_pc);
            chk("pairing", {32'h0, instruction_o}, {32'h0, inst_of(PC_o)});
            got_pc.push_back(PC_o);
            got_ins.push_back(instruction_o);
            seq_pc = seq_pc + 64'd4;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
         end
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_log(input string nm, input int idx, input logic [63:0] pc, input logic [31:0] ins);
      chk({nm, "_present"}, {63'h0, got_pc.size() > idx}, 64'h1);
      if (got_pc.size() > idx) begin
         chk({nm, "_pc"}, got_pc[idx], pc);
         chk({nm, "_ins"}, {32'h0, got_ins[idx]}, {32'h0, ins});
      end
   endtask

   task automatic clear_log();
      got_pc.delete();
      got_ins.delete();
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, "_valid"}, {63'h0, valid_o}, 64'h0);
      chk({nm, "_req"}, {63'h0, imem_req_valid_o}, 64'h0);
      chk({nm, "_ins"}, {32'h0, instruction_o}, {32'h0, Nop});
      chk({nm, "_pc"}, PC_o, 64'h0);
   endtask

   initial begin
      bit found;
      repeat (3) step();
      #1 chk_idle("reset");
      // 1: stream from ResetPC with 1-cycle memory; second PC wraps to 0
      reset_ni = 1'b1;
      rel_cyc = cyc;
      repeat (12) step();
      chk_log("t1_0", 0, RstPc, 32'hEDCB_A984);
      chk_log("t1_1", 1, 64'h0, 32'h1234_5678);
      chk_log("t1_2", 2, 64'h4, 32'h1234_567C);
      chk("t1_latency", 64'(first_valid_cyc - rel_cyc), 64'd3);
      // 2: downstream stall fills the FIFO and stops requests
      ready_i = 1'b0;
      repeat (5) step();
      #1;
      chk("t2_req_blocked", {63'h0, imem_req_valid_o}, 64'h0);
      chk("t2_valid_held", {63'h0, valid_o}, 64'h1);
      ready_i = 1'b1;
      repeat (8) step();
      // 3: redirect with two requests in flight, 3-cycle memory
      lat = 3;
      reset_ni = 1'b0;
      step();
      reset_ni = 1'b1;
      step();
      step();
      step();
      #1;
      chk("t3_two_inflight_req", {63'h0, imem_req_valid_o}, 64'h0);
      chk("t3_two_inflight_valid", {63'h0, valid_o}, 64'h0);
      redirect_valid_i = 1'b1;
      redirect_pc_i = 64'h103;
      clear_log();
      step();
      redirect_valid_i = 1'b0;
      repeat (12) step();
      chk_log("t3", 0, 64'h100, 32'h1234_5778);
      // 4: redirect coinciding with a response and a pop
      lat = 1;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         #2;
         if (imem_rsp_valid_i && valid_o) found = 1;
      end
      chk("t4_found_slot", {63'h0, found}, 64'h1);
      redirect_valid_i = 1'b1;
      redirect_pc_i = 64'h200;
      clear_log();
      step();
      redirect_valid_i = 1'b0;
      repeat (10) step();
      chk_log("t4", 0, 64'h200, 32'h1234_5478);
      // 5: random request back-pressure and downstream stalls, 3-cycle memory
      lat = 3;
      for (int i = 0; i < 60; i++) begin
         imem_req_ready_i = 1'($urandom_range(0, 1));
         ready_i = ($urandom_range(0, 3) != 0);
         step();
      end
      imem_req_ready_i = 1'b1;
      ready_i = 1'b1;
      repeat (15) step();
      // 6: reset in mid-stream
      lat = 1;
      repeat (4) step();
      reset_ni = 1'b0;
      step();
      reset_ni = 1'b1;
      #1 chk_idle("t6_after_reset");
      clear_log();
      repeat (10) step();
      chk_log("t6_0", 0, RstPc, 32'hEDCB_A984);
      chk_log("t6_1", 1, 64'h0, 32'h1234_5678);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
